sudoku_bin2hex_serial: RTL and testbench

//  Inverse of the checker's per-cell hex-to-one-hot expansion: converts a 9x9 board of 9-bit
//  one-hot cells back to packed 4-bit digits for readback/debug/result reporting.

---
 rtl/sudoku_pkg.sv | 17 +
 rtl/sudoku_bin2hex_serial_if.sv | 27 ++
 rtl/bin2hex_cell.sv | 21 ++
 rtl/sudoku_bin2hex_serial.sv | 137 +++++++++++++
 tb/tb_sudoku_bin2hex_serial.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants and state encoding for the sudoku bin/hex conversion blocks.
package sudoku_pkg;

    localparam int unsigned NUM_CELLS   = 81;
    localparam int unsigned DIGIT_W     = 9;
    localparam int unsigned HEX_W       = 4;
    localparam int unsigned BOARD_BIN_W = NUM_CELLS * DIGIT_W;
    localparam int unsigned BOARD_HEX_W = NUM_CELLS * HEX_W;
    localparam int unsigned CELL_IDX_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sudoku_bin2hex_serial_if.sv
// Board-in / result-out handshake bundle for sudoku_bin2hex_serial.
interface sudoku_bin2hex_serial_if;
    import sudoku_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [BOARD_BIN_W-1:0]     bin;
    logic                       out_valid;
    logic                       out_ready;
    logic [BOARD_HEX_W-1:0]     hex;
    logic                       err;
    logic [CELL_IDX_W-1:0]      err_cell;
    logic                       busy;

    // Producer/consumer side of the converter.
    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, hex, err, err_cell, busy
    );

    // Converter side.
    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, hex, err, err_cell, busy
    );

endinterface

// File: rtl/bin2hex_cell.sv
// One-hot cell to packed digit: bit k -> k+1, zero -> 0, multi-bit -> 0 and invalid.
module bin2hex_cell
    import sudoku_pkg::*;
(
    input  logic [DIGIT_W-1:0] bin,
    output logic [HEX_W-1:0]   hex,
    output logic               invalid
);

    // Multi-bit detect via clear-lowest-bit trick, then priority-free digit decode.
    always_comb begin
        invalid = (bin & (bin - 9'd1)) != '0;
        hex     = '0;
        if (!invalid) begin
            for (int unsigned k = 0; k < DIGIT_W; k++) begin
                if (bin[k]) hex = HEX_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/sudoku_bin2hex_serial.sv
// Serial one-hot board to packed hex converter with first-invalid-cell reporting.
module sudoku_bin2hex_serial
    import sudoku_pkg::*;
#(
    parameter int unsigned CELLS_PER_CYCLE = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    sudoku_bin2hex_serial_if.slave bus
);

    localparam int unsigned GROUPS = NUM_CELLS / CELLS_PER_CYCLE;
    localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BOARD_BIN_W-1:0] board_q, board_d;
    logic [BOARD_HEX_W-1:0] hex_q, hex_d;
    logic                   err_q, err_d;
    logic [CELL_IDX_W-1:0]  err_cell_q, err_cell_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic [CELL_IDX_W-1:0]  lane_idx [CELLS_PER_CYCLE];
    logic [DIGIT_W-1:0]     lane_bin [CELLS_PER_CYCLE];
    logic [HEX_W-1:0]       lane_hex [CELLS_PER_CYCLE];
    logic                   lane_inv [CELLS_PER_CYCLE];
    logic                   found;
    logic [CELL_IDX_W-1:0]  first_idx;

    // Select the cnt-th group of cells from the latched board.
    always_comb begin
        for (int unsigned j = 0; j < CELLS_PER_CYCLE; j++) begin
            lane_idx[j] = CELL_IDX_W'(32'(cnt_q) * CELLS_PER_CYCLE + j);
            lane_bin[j] = board_q[lane_idx[j]*DIGIT_W +: DIGIT_W];
        end
    end

    for (genvar g = 0; g < CELLS_PER_CYCLE; g++) begin : g_lane
        bin2hex_cell u_cell (
            .bin     (lane_bin[g]),
            .hex     (lane_hex[g]),
            .invalid (lane_inv[g])
        );
    end

    // Next-state, group write-back and sticky first-error capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        board_d    = board_q;
        hex_d      = hex_q;
        err_d      = err_q;
        err_cell_d = err_cell_q;
        found      = 1'b0;
        first_idx  = '0;

        // Ascending scan with a found flag so the lowest lane in the group wins.
        for (int unsigned j = 0; j < CELLS_PER_CYCLE; j++) begin
            if (lane_inv[j] && !found) begin
                found     = 1'b1;
                first_idx = lane_idx[j];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    board_d    = bus.bin;
                    hex_d      = '0;
                    err_d      = 1'b0;
                    err_cell_d = '0;
                    cnt_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                for (int unsigned j = 0; j < CELLS_PER_CYCLE; j++) begin
                    hex_d[lane_idx[j]*HEX_W +: HEX_W] = lane_hex[j];
                end
                if (found && !err_q) begin
                    err_d      = 1'b1;
                    err_cell_d = first_idx;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            board_q     <= '0;
            hex_q       <= '0;
            err_q       <= 1'b0;
            err_cell_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            board_q     <= board_d;
            hex_q       <= hex_d;
            err_q       <= err_d;
            err_cell_q  <= err_cell_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.hex       = hex_q;
    assign bus.err       = err_q;
    assign bus.err_cell  = err_cell_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sudoku_bin2hex_serial.sv
// Bench for sudoku_bin2hex_serial at CELLS_PER_CYCLE = 9, 1 and 81.
module tb_sudoku_bin2hex_serial;
    import sudoku_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   sel = 2'd0;
    logic         drive_valid = 1'b0;
    logic         drive_ready = 1'b1;
    logic [728:0] drive_bin = '0;

    int n_checks = 0;
    int n_fail   = 0;

    sudoku_bin2hex_serial_if if9 ();
    sudoku_bin2hex_serial_if if1 ();
    sudoku_bin2hex_serial_if if81 ();

    assign if9.in_valid   = (sel == 2'd0) && drive_valid;
    assign if1.in_valid   = (sel == 2'd1) && drive_valid;
    assign if81.in_valid  = (sel == 2'd2) && drive_valid;
    assign if9.bin        = drive_bin;
    assign if1.bin        = drive_bin;
    assign if81.bin       = drive_bin;
    assign if9.out_ready  = (sel == 2'd0) ? drive_ready : 1'b1;
    assign if1.out_ready  = (sel == 2'd1) ? drive_ready : 1'b1;
    assign if81.out_ready = (sel == 2'd2) ? drive_ready : 1'b1;

    sudoku_bin2hex_serial #(.CELLS_PER_CYCLE(9))  dut9  (.clk(clk), .rst(rst), .bus(if9));
    sudoku_bin2hex_serial #(.CELLS_PER_CYCLE(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    sudoku_bin2hex_serial #(.CELLS_PER_CYCLE(81)) dut81 (.clk(clk), .rst(rst), .bus(if81));

    logic         o_in_ready, o_out_valid, o_err, o_busy;
    logic [323:0] o_hex;
    logic [6:0]   o_err_cell;

    always_comb begin
        case (sel)
            2'd0: begin
                o_in_ready = if9.in_ready;  o_out_valid = if9.out_valid;  o_err = if9.err;
                o_busy = if9.busy;  o_hex = if9.hex;  o_err_cell = if9.err_cell;
            end
            2'd1: begin
                o_in_ready = if1.in_ready;  o_out_valid = if1.out_valid;  o_err = if1.err;
                o_busy = if1.busy;  o_hex = if1.hex;  o_err_cell = if1.err_cell;
            end
            default: begin
                o_in_ready = if81.in_ready; o_out_valid = if81.out_valid; o_err = if81.err;
                o_busy = if81.busy; o_hex = if81.hex; o_err_cell = if81.err_cell;
            end
        endcase
    end

    task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each cell is a digit if it equals exactly one power of two.
    function automatic void model(input logic [728:0] b, output logic [323:0] h,
                                  output logic e, output logic [6:0] ec);
        logic [8:0] c;
        h = '0; e = 1'b0; ec = '0;
        for (int i = 0; i < 81; i++) begin
            c = b[i*9 +: 9];
            if ($countones(c) > 1) begin
                if (!e) begin
                    e  = 1'b1;
                    ec = 7'(i);
                end
            end else begin
                for (int k = 0; k < 9; k++)
                    if (c == (9'd1 << k)) h[i*4 +: 4] = 4'(k + 1);
            end
        end
    endfunction

    function automatic logic [728:0] rand_bits();
        logic [735:0] r;
        for (int i = 0; i < 23; i++) r[i*32 +: 32] = $urandom;
        return r[728:0];
    endfunction

    function automatic logic [728:0] rand_board(input bit inv);
        logic [728:0] b;
        int unsigned r, a, s;
        b = '0;
        for (int i = 0; i < 81; i++) begin
            r = $urandom_range(0, 9);
            if (r != 0) b[i*9 +: 9] = 9'd1 << (r - 1);
            if (inv && $urandom_range(0, 15) == 0) begin
                a = $urandom_range(0, 8);
                s = (a + 1 + $urandom_range(0, 7)) % 9;
                b[i*9 +: 9] = (9'd1 << a) | (9'd1 << s);
            end
        end
        return b;
    endfunction

    function automatic logic [728:0] solved_board();
        logic [728:0] b;
        int d;
        b = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                d = ((r * 3 + r / 3 + c) % 9) + 1;
                b[(r*9+c)*9 +: 9] = 9'd1 << (d - 1);
            end
        return b;
    endfunction

    // Called at the negedge right after the accept edge; waits for the result.
    task automatic wait_done(input logic [728:0] b, input int lat, input string tag);
        logic [323:0] eh;
        logic         ee;
        logic [6:0]   eec;
        int           cyc;
        model(b, eh, ee, eec);
        cyc = 0;
        while (!o_out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 324'(cyc), 324'(lat));
        check({tag, "_hex"}, o_hex, eh);
        check({tag, "_err"}, 324'(o_err), 324'(ee));
        check({tag, "_err_cell"}, 324'(o_err_cell), 324'(eec));
        check({tag, "_busy"}, 324'(o_busy), 324'(1));
        @(negedge clk);
        check({tag, "_ov_drop"}, 324'(o_out_valid), 324'(0));
        check({tag, "_ready_back"}, 324'(o_in_ready), 324'(1));
    endtask

    task automatic run_board(input logic [728:0] b, input int lat, input string tag);
        @(negedge clk);
        drive_ready = 1'b1;
        check({tag, "_in_ready"}, 324'(o_in_ready), 324'(1));
        drive_valid = 1'b1;
        drive_bin   = b;
        @(negedge clk);
        drive_valid = 1'b0;
        drive_bin   = rand_bits();
        wait_done(b, lat, tag);
    endtask

    logic [728:0] brd, brd_b;
    logic [323:0] eh;
    logic         ee;
    logic [6:0]   eec;
    logic         saw_ov;
    int           cyc;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 324'(o_in_ready), 324'(1));
        check("rst_busy", 324'(o_busy), 324'(0));
        check("rst_out_valid", 324'(o_out_valid), 324'(0));
        check("rst_hex", o_hex, '0);
        check("rst_err", 324'(o_err), 324'(0));
        check("rst_err_cell", 324'(o_err_cell), 324'(0));

        // Reset in the middle of a conversion.
        @(negedge clk);
        drive_valid = 1'b1;
        drive_bin   = solved_board();
        @(negedge clk);
        drive_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midconv_busy", 324'(o_busy), 324'(1));
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 324'(o_in_ready), 324'(1));
        check("midrst_busy", 324'(o_busy), 324'(0));
        check("midrst_hex", o_hex, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_ov = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw_ov |= o_out_valid;
        end
        check("midrst_no_ov", 324'(saw_ov), 324'(0));
        check("midrst_hex_after", o_hex, '0);
        check("midrst_ready_after", 324'(o_in_ready), 324'(1));

        // Solved board, single-bit sweep, empty board and invalid cells.
        run_board(solved_board(), 9, "solved9");
        brd = '0;
        for (int i = 0; i < 81; i++) brd[i*9 +: 9] = 9'd1 << (i % 9);
        run_board(brd, 9, "sweep9");
        run_board('0, 9, "empty9");
        brd = '0;
        brd[5*9 +: 9]  = 9'h003;
        brd[40*9 +: 9] = 9'h180;
        run_board(brd, 9, "inv9");
        for (int n = 0; n < 5; n++) run_board(rand_board(1'b1), 9, "rand9");

        // Backpressure: result must hold while in_valid and bin churn.
        brd = rand_board(1'b1);
        model(brd, eh, ee, eec);
        @(negedge clk);
        drive_ready = 1'b0;
        drive_valid = 1'b1;
        drive_bin   = brd;
        @(negedge clk);
        drive_bin = rand_bits();
        cyc = 0;
        while (!o_out_valid && cyc < 300) begin
            @(negedge clk);
            drive_bin = rand_bits();
            cyc++;
        end
        check("bp_latency", 324'(cyc), 324'(9));
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            drive_bin = rand_bits();
            check("bp_ov_held", 324'(o_out_valid), 324'(1));
            check("bp_in_ready", 324'(o_in_ready), 324'(0));
            check("bp_hex_frozen", o_hex, eh);
            check("bp_err_frozen", {o_err, o_err_cell}, {ee, eec});
        end
        brd_b = rand_board(1'b1);
        drive_ready = 1'b1;
        drive_bin   = brd_b;
        @(negedge clk);
        check("bp_hs_ov", 324'(o_out_valid), 324'(0));
        check("bp_hs_idle", 324'(o_busy), 324'(0));
        @(negedge clk);
        drive_valid = 1'b0;
        check("bp_next_accepted", 324'(o_busy), 324'(1));
        wait_done(brd_b, 9, "bp_next");

        // Other group widths give identical results at their own latency.
        sel = 2'd1;
        run_board(solved_board(), 81, "solved1");
        run_board(brd, 81, "inv1");
        run_board(rand_board(1'b1), 81, "rand1");
        sel = 2'd2;
        run_board(solved_board(), 1, "solved81");
        run_board(brd, 1, "inv81");
        run_board(rand_board(1'b1), 1, "rand81");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
